// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmitter arbiter.
package uart_arb_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Timeout counter only has to hold LOCK_TIMEOUT-1.
    function automatic int unsigned cnt_w(input int unsigned t);
        return (t < 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] sel
);

    logic [N-1:0] rot;
    logic [W-1:0] idx;
    int           off;

    // Rotate so bit 0 is ptr+1, priority-encode, then map the offset back.
    always_comb begin
        rot   = '0;
        idx   = '0;
        found = 1'b0;
        off   = 0;
        for (int i = 0; i < int'(N); i++) begin
            idx    = W'((int'(ptr) + 1 + i) % int'(N));
            rot[i] = req[idx];
        end
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
        sel = W'((int'(ptr) + 1 + off) % int'(N));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock and lock timeout in front of one UART transmitter.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [id_w(NUM_REQ)-1:0]   grant_id,
    output logic                       locked,
    output logic                       lock_timeout
);

    localparam int unsigned ID_W  = id_w(NUM_REQ);
    localparam int unsigned CNT_W = cnt_w(LOCK_TIMEOUT);

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic             pick_found;
    logic [ID_W-1:0]  pick_sel;
    logic             found;
    logic [ID_W-1:0]  sel;
    logic             cnt_hit;

    rr_pick #(.N(NUM_REQ), .W(ID_W)) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .sel   (pick_sel)
    );

    // A held lock restricts eligibility to the current owner.
    always_comb begin
        found = pick_found;
        sel   = pick_sel;
        if (locked) begin
            found = req_valid[grant_id];
            sel   = grant_id;
        end
    end

    assign cnt_hit = (cnt == CNT_W'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= ID_W'(NUM_REQ - 1);
            cnt          <= '0;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            req_ready    <= '0;
            grant_id     <= '0;
            locked       <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            tx_start     <= 1'b0;
            req_ready    <= '0;
            lock_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found && !tx_busy) begin
                        tx_data   <= req_data[{sel, 3'b000} +: 8];
                        grant_id  <= sel;
                        tx_start  <= 1'b1;
                        req_ready <= NUM_REQ'(1) << sel;
                        cnt       <= '0;
                        state     <= WAIT_BUSY;
                        if (req_last[sel]) begin
                            locked <= 1'b0;
                            ptr    <= sel;
                        end else begin
                            locked <= 1'b1;
                        end
                    end else if (locked && !req_valid[grant_id]) begin
                        // Owner stalled: count idle cycles, then hand the link back.
                        if (cnt_hit) begin
                            locked       <= 1'b0;
                            ptr          <= grant_id;
                            lock_timeout <= 1'b1;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                WAIT_BUSY: state <= WAIT_DONE;
                WAIT_DONE: if (!tx_busy) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a cycle-level behavioural model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int LT = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } item_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_last = '0;
    logic [NR-1:0]   req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy = 1'b0;
    logic [1:0]      grant_id;
    logic            locked;
    logic            lock_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(LT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .locked       (locked),
        .lock_timeout (lock_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    item_t      lane_q[NR][$];
    int         wait_cnt[NR];
    logic [7:0] sent_log[$];

    int         cyc = 0, idle_at = 0, busy_clear_at = -1, busy_len = 0, to_count = 0;
    logic       busy_int = 1'b0, ext_busy = 1'b0;
    int         m_ptr = NR - 1, m_owner = 0, m_cnt = 0;
    logic       m_locked = 1'b0;
    logic [7:0] m_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic push(input int lane, input logic [7:0] d, input logic last, input int gap);
        item_t it;
        it.data = d; it.last = last; it.gap = gap;
        lane_q[lane].push_back(it);
    endtask

    // Eligibility straight from the arbitration rules.
    function automatic int model_pick();
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 1; k <= NR; k++) begin
            if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic pending();
        logic p = (req_valid != '0) || (cyc < idle_at);
        for (int l = 0; l < NR; l++) if (lane_q[l].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic cycle();
        int            lane, l_len;
        logic          exp_start, exp_to;
        logic [NR-1:0] exp_ready;
        @(posedge clk);
        #1;
        cyc++;
        exp_start = 1'b0; exp_to = 1'b0; exp_ready = '0;
        if (cyc >= idle_at) begin
            lane = model_pick();
            if (lane >= 0 && !tx_busy) begin
                exp_start       = 1'b1;
                exp_ready[lane] = 1'b1;
                m_data          = req_data[lane*8 +: 8];
                m_owner         = lane;
                m_cnt           = 0;
                if (req_last[lane]) begin
                    m_locked = 1'b0;
                    m_ptr    = lane;
                end else begin
                    m_locked = 1'b1;
                end
                l_len         = (busy_len > 0) ? busy_len : int'($urandom_range(1, 4));
                busy_int      = 1'b1;
                busy_clear_at = cyc + l_len;
                idle_at       = cyc + l_len + 2;
            end else if (m_locked && !req_valid[m_owner]) begin
                m_cnt++;
                if (m_cnt == LT) begin
                    exp_to   = 1'b1;
                    m_locked = 1'b0;
                    m_ptr    = m_owner;
                    m_cnt    = 0;
                end
            end
        end
        if (!exp_start && cyc == busy_clear_at) busy_int = 1'b0;

        check("tx_start", 32'(tx_start), 32'(exp_start));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("lock_timeout", 32'(lock_timeout), 32'(exp_to));
        check("locked", 32'(locked), 32'(m_locked));
        check("grant_id", 32'(grant_id), 32'(m_owner));
        check("tx_data", 32'(tx_data), 32'(m_data));
        if (tx_start) sent_log.push_back(tx_data);
        if (lock_timeout) to_count++;

        tx_busy = busy_int | ext_busy;
        for (int l = 0; l < NR; l++) begin
            if (exp_ready[l]) begin
                void'(lane_q[l].pop_front());
                req_valid[l] = 1'b0;
                wait_cnt[l]  = 0;
            end
            if (!req_valid[l]) begin
                if (lane_q[l].size() == 0) begin
                    wait_cnt[l] = 0;
                end else if (wait_cnt[l] >= lane_q[l][0].gap) begin
                    req_valid[l]       = 1'b1;
                    req_data[l*8 +: 8] = lane_q[l][0].data;
                    req_last[l]        = lane_q[l][0].last;
                end else begin
                    wait_cnt[l]++;
                end
            end
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_lock_timeout", 32'(lock_timeout), 32'd0);
        m_ptr = NR - 1; m_owner = 0; m_cnt = 0; m_locked = 1'b0; m_data = 8'h00;
        busy_int = 1'b0; ext_busy = 1'b0; tx_busy = 1'b0; busy_clear_at = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle_at = cyc + 1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (pending() && k < budget) begin
            cycle();
            k++;
        end
        check("drain", 32'(pending()), 32'd0);
    endtask

    task automatic expect_log(input string tag, input int base, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                              input int n);
        logic [7:0] ex[4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        check({tag, "_count"}, 32'(sent_log.size() - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (base + k < sent_log.size()) check(tag, 32'(sent_log[base + k]), 32'(ex[k]));
            else check(tag, 32'hFFFF_FFFF, 32'(ex[k]));
        end
    endtask

    initial begin
        int base, t0, k;
        for (int l = 0; l < NR; l++) wait_cnt[l] = 0;
        #2;
        apply_reset();

        // Fairness: two always-ready single-byte lanes alternate.
        base = sent_log.size();
        push(0, 8'h10, 1'b1, 0); push(0, 8'h10, 1'b1, 0);
        push(2, 8'h20, 1'b1, 0); push(2, 8'h20, 1'b1, 0);
        drain(200);
        expect_log("fair", base, 8'h10, 8'h20, 8'h10, 8'h20, 4);

        // Single byte on lane 1.
        base = sent_log.size();
        push(1, 8'hAA, 1'b1, 0);
        drain(100);
        expect_log("single", base, 8'hAA, 8'h00, 8'h00, 8'h00, 1);

        // Packet lock holds off lane 0 until the last byte.
        base = sent_log.size();
        push(1, 8'h11, 1'b0, 0); push(1, 8'h22, 1'b0, 0); push(1, 8'h33, 1'b1, 0);
        push(0, 8'h55, 1'b1, 2);
        drain(200);
        expect_log("lock", base, 8'h11, 8'h22, 8'h33, 8'h55, 4);

        // Stalled owner is released after the timeout.
        base = sent_log.size();
        t0 = to_count;
        push(3, 8'h77, 1'b0, 0); push(3, 8'h78, 1'b1, 40);
        push(2, 8'h99, 1'b1, 3);
        drain(300);
        expect_log("timeout", base, 8'h77, 8'h99, 8'h78, 8'h00, 3);
        check("timeout_pulses", 32'(to_count - t0), 32'd1);

        // External busy in IDLE blocks grants.
        base = sent_log.size();
        ext_busy = 1'b1; tx_busy = 1'b1;
        push(0, 8'hE0, 1'b1, 0);
        repeat (6) cycle();
        check("busy_block", 32'(sent_log.size() - base), 32'd0);
        ext_busy = 1'b0; tx_busy = busy_int;
        drain(100);
        expect_log("busy_release", base, 8'hE0, 8'h00, 8'h00, 8'h00, 1);

        // Reset during WAIT_DONE; pending lane 0 byte goes out first after release.
        base = sent_log.size();
        busy_len = 6;
        push(1, 8'hB0, 1'b1, 0);
        k = 0;
        while (sent_log.size() == base && k < 20) begin
            cycle();
            k++;
        end
        check("rst_first_start", 32'(sent_log.size() - base), 32'd1);
        push(0, 8'hC0, 1'b1, 0);
        cycle();
        cycle();
        #3;
        apply_reset();
        cycle();
        check("rst_regrant", 32'(tx_start), 32'd1);
        drain(100);
        expect_log("rst_seq", base, 8'hB0, 8'hC0, 8'h00, 8'h00, 2);
        busy_len = 0;

        // Random traffic with mixed packet lengths and occasional stalls.
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < NR; l++) begin
                if (lane_q[l].size() < 2 && $urandom_range(0, 3) == 0) begin
                    int len = int'($urandom_range(1, 3));
                    for (int b = 0; b < len; b++) begin
                        int g;
                        if (b == 0) g = int'($urandom_range(0, 6));
                        else if ($urandom_range(0, 9) == 0) g = int'($urandom_range(18, 30));
                        else g = int'($urandom_range(0, 2));
                        push(l, 8'($urandom), (b == len - 1), g);
                    end
                end
            end
            cycle();
        end
        drain(2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
